// File: rtl/simon_seq_engine.sv
// simon_seq_engine
//   Sequence-memory game core. The player enters a pattern, the stored sequence
//   is played back, and the player repeats it. A correct repeat adds a new round.
//   The game ends in DONE on a failed repeat, or in WIN once the memory is full.
//
//   Parameters: PAT_W (pattern width), DEPTH (max sequence length),
//               LIVES (retries per game when retries are enabled)
//   Optional:   `define SIMON_RETRY_EN turns on retry lives. When it is left
//               undefined, lives_left is always 0 and any mismatch ends the game.
//
//   Ports:
//     clk           system clock, rising edge
//     rst           synchronous active-low reset
//     press         single-cycle advance strobe
//     level         0: any nonzero pattern is valid, 1: only one-hot patterns
//     pattern       switch inputs
//     pattern_leds  pattern being displayed
//     mode_leds     INPUT=001 PLAYBACK=010 REPEAT=100 DONE=111 WIN=011
//     score         current sequence length
//     lives_left    remaining retries
//
//   state    | meaning
//   S_INPUT    | waiting for the player to add a new pattern
//   S_PLAYBACK | stepping through the stored sequence, one entry per press
//   S_REPEAT   | player repeats the sequence, one entry per press
//   S_DONE     | lost; each press cycles through the sequence until reset
//   S_WIN      | memory full; each press cycles through the sequence until reset
module simon_seq_engine #(
  parameter int PAT_W = 4,
  parameter int DEPTH = 64,
  parameter int LIVES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       press,
  input  logic                       level,
  input  logic [PAT_W-1:0]           pattern,
  output logic [PAT_W-1:0]           pattern_leds,
  output logic [2:0]                 mode_leds,
  output logic [$clog2(DEPTH+1)-1:0] score,
  output logic [2:0]                 lives_left
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

`ifdef SIMON_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // Without retries the counter resets to 0 and never moves.
  localparam logic [2:0] LIVES_RST = RETRY ? 3'(LIVES) : 3'd0;

  // The state encoding is the mode LED code, so the LEDs decode for free.
  typedef enum logic [2:0] {
    S_INPUT    = 3'b001,
    S_PLAYBACK = 3'b010,
    S_REPEAT   = 3'b100,
    S_DONE     = 3'b111,
    S_WIN      = 3'b011
  } state_t;

  state_t         state, state_nxt;
  logic [LW-1:0]  len, len_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [2:0]     lives, lives_nxt;
  logic           mem_we;
  logic [PAT_W-1:0] mem [DEPTH];
  logic [PAT_W-1:0] cur;
  logic           is_last;
  logic           valid;

  assign cur = mem[idx];
  // Written as idx+1 == len so that len=0 never underflows.
  assign is_last = ((LW'(idx) + LW'(1)) == len);
  assign valid = (pattern != '0) && (!level || ($countones(pattern) == 1));

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idx_nxt   = idx;
    lives_nxt = lives;
    mem_we    = 1'b0;
    if (press) begin
      case (state)
        S_INPUT: begin
          if (valid) begin
            mem_we    = 1'b1;
            len_nxt   = len + LW'(1);
            idx_nxt   = '0;
            state_nxt = S_PLAYBACK;
          end
        end
        S_PLAYBACK: begin
          if (is_last) begin
            idx_nxt   = '0;
            state_nxt = S_REPEAT;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
        S_REPEAT: begin
          if (pattern == cur) begin
            if (is_last) begin
              idx_nxt   = '0;
              state_nxt = (len == LW'(DEPTH)) ? S_WIN : S_INPUT;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            idx_nxt = '0;
            if (RETRY && (lives != 3'd0)) begin
              lives_nxt = lives - 3'd1;
              state_nxt = S_PLAYBACK;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DONE, S_WIN: begin
          idx_nxt = is_last ? '0 : idx + IW'(1);
        end
        default: begin
          idx_nxt   = '0;
          state_nxt = S_INPUT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_INPUT;
      len   <= '0;
      idx   <= '0;
      lives <= LIVES_RST;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      idx   <= idx_nxt;
      lives <= lives_nxt;
    end
  end

  // Memory is not cleared by reset. Writes only happen in INPUT, where
  // len < DEPTH always holds because a full memory ends in WIN.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[len[IW-1:0]] <= pattern;
    end
  end

  always_comb begin
    case (state)
      S_INPUT, S_REPEAT: pattern_leds = pattern;
      default:           pattern_leds = cur;
    endcase
  end

  assign mode_leds  = state;
  assign score      = len;
  assign lives_left = lives;

endmodule
